// File: rtl/parking_ctrl_param.sv
// Parking gate controller: BCD PIN entry, retry-limited wrong-PIN alarm, tailgate detection, vehicle counter.
// Optional build macro GATE_TIMEOUT_EN closes an unused open gate after GATE_TIMEOUT cycles.
module parking_ctrl_param #(
    parameter int NUM_DIGITS   = 4,
    parameter int MAX_TRIES    = 3,
    parameter int CNT_W        = 8,
    parameter int GATE_TIMEOUT = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sensor_vehicule,
    input  logic                            sensor_moved_vehicule,
    input  logic                            password_valid,
    input  logic [4*NUM_DIGITS-1:0]         password_input,
    input  logic [4*NUM_DIGITS-1:0]         correct_password,
    output logic                            open_gate,
    output logic                            close_gate,
    output logic                            alarm_wrong_pin,
    output logic                            alarm_blocked,
    output logic [$clog2(MAX_TRIES+1)-1:0]  fail_count,
    output logic [CNT_W-1:0]                vehicle_count
);

    localparam int PW = 4 * NUM_DIGITS;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(GATE_TIMEOUT + 1);

    if (NUM_DIGITS < 1 || MAX_TRIES < 1 || CNT_W < 1 || GATE_TIMEOUT < 1) begin : g_bad_param
        $error("parking_ctrl_param: all parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PIN  = 3'd1,
        WRONG_PIN = 3'd2,
        OPEN      = 3'd3,
        BLOCKED   = 3'd4
    } state_t;

    // A PIN equal to the reference still fails if any digit is outside 0-9.
    function automatic logic all_bcd(input logic [PW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
            else                    ok = ok;
        end
        return ok;
    endfunction

    state_t           state_r, state_s;
    logic [FW-1:0]    fail_r, fail_s;
    logic [CNT_W-1:0] vcount_r, vcount_s;
    logic             pin_ok_s;
    logic             timeout_s;
    logic             open_gate_r, close_gate_r, alarm_wrong_pin_r, alarm_blocked_r;

    assign pin_ok_s = password_valid && (password_input == correct_password)
                      && all_bcd(password_input);

`ifdef GATE_TIMEOUT_EN
    logic [TW-1:0] timer_r;

    // Dwell timer: runs only while the gate stays open, restarts on every entry to OPEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (state_r == OPEN && state_s == OPEN) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= '0;
        end
    end

    assign timeout_s = (timer_r == TW'(GATE_TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, retry counter and vehicle counter decode.
    always_comb begin
        state_s  = state_r;
        fail_s   = fail_r;
        vcount_s = vcount_r;
        case (state_r)
            IDLE: begin
                if (sensor_vehicule) state_s = WAIT_PIN;
                else                 state_s = IDLE;
            end
            WAIT_PIN: begin
                if (password_valid) begin
                    if (pin_ok_s) begin
                        state_s = OPEN;
                        fail_s  = '0;
                    end else begin
                        fail_s = fail_r + FW'(1);
                        if (fail_s == FW'(MAX_TRIES)) state_s = WRONG_PIN;
                        else                          state_s = WAIT_PIN;
                    end
                end else if (!sensor_vehicule) begin
                    state_s = IDLE;
                    fail_s  = '0;
                end else begin
                    state_s = WAIT_PIN;
                end
            end
            WRONG_PIN: begin
                // Alarm stays latched even if the vehicle leaves.
                if (pin_ok_s) begin
                    state_s = OPEN;
                    fail_s  = '0;
                end else begin
                    state_s = WRONG_PIN;
                    fail_s  = FW'(MAX_TRIES);
                end
            end
            OPEN: begin
                if (sensor_vehicule && sensor_moved_vehicule) begin
                    state_s = BLOCKED;
                end else if (sensor_moved_vehicule) begin
                    state_s  = IDLE;
                    vcount_s = vcount_r + CNT_W'(1);
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = OPEN;
                end
            end
            BLOCKED: begin
                if (pin_ok_s && !sensor_vehicule && !sensor_moved_vehicule) state_s = IDLE;
                else                                                        state_s = BLOCKED;
            end
            default: begin
                state_s = IDLE;
                fail_s  = '0;
            end
        endcase
    end

    // State, counters and Moore outputs, all registered from the decoded next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= IDLE;
            fail_r            <= '0;
            vcount_r          <= '0;
            open_gate_r       <= 1'b0;
            close_gate_r      <= 1'b1;
            alarm_wrong_pin_r <= 1'b0;
            alarm_blocked_r   <= 1'b0;
        end else begin
            state_r           <= state_s;
            fail_r            <= fail_s;
            vcount_r          <= vcount_s;
            open_gate_r       <= (state_s == OPEN);
            close_gate_r      <= (state_s != OPEN);
            alarm_wrong_pin_r <= (state_s == WRONG_PIN);
            alarm_blocked_r   <= (state_s == BLOCKED);
        end
    end

    assign open_gate       = open_gate_r;
    assign close_gate      = close_gate_r;
    assign alarm_wrong_pin = alarm_wrong_pin_r;
    assign alarm_blocked   = alarm_blocked_r;
    assign fail_count      = fail_r;
    assign vehicle_count   = vcount_r;

endmodule

// File: tb/tb_parking_ctrl_param.sv
// Scoreboard bench for parking_ctrl_param (4 digits, 3 tries, 8-bit count, timeout 10 when enabled).
module tb_parking_ctrl_param;

    localparam logic [15:0] PIN  = 16'h3761;
    localparam logic [3:0]  NONE = 4'b0000, RST = 4'b1000, SV = 4'b0100, SMV = 4'b0010, PV = 4'b0001;
    localparam logic [2:0]  CLS  = 3'b000, OPN = 3'b100, AW = 3'b010, AB = 3'b001;

    typedef struct {
        logic [3:0]  ctl;   // {rst, sensor_vehicule, sensor_moved_vehicule, password_valid}
        logic [15:0] pin;
        logic [15:0] cp;
        logic [2:0]  flags; // {open_gate, alarm_wrong_pin, alarm_blocked}
        logic [1:0]  fail;
        logic [7:0]  vc;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sensor_vehicule = 1'b0, sensor_moved_vehicule = 1'b0, password_valid = 1'b0;
    logic [15:0] password_input = 16'h0, correct_password = PIN;
    logic        open_gate, close_gate, alarm_wrong_pin, alarm_blocked;
    logic [1:0]  fail_count;
    logic [7:0]  vehicle_count;

    logic [13:0] sb[$];
    logic [13:0] got, exp;
    int          n_cmp = 0;
    int          n_mis = 0;

    parking_ctrl_param #(
        .NUM_DIGITS(4), .MAX_TRIES(3), .CNT_W(8), .GATE_TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst),
        .sensor_vehicule(sensor_vehicule), .sensor_moved_vehicule(sensor_moved_vehicule),
        .password_valid(password_valid), .password_input(password_input),
        .correct_password(correct_password),
        .open_gate(open_gate), .close_gate(close_gate),
        .alarm_wrong_pin(alarm_wrong_pin), .alarm_blocked(alarm_blocked),
        .fail_count(fail_count), .vehicle_count(vehicle_count)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic [3:0] ctl, input logic [15:0] pin,
                                input logic [2:0] flags, input logic [1:0] fail, input logic [7:0] vc);
        row_t r;
        r.ctl = ctl; r.pin = pin; r.cp = PIN; r.flags = flags; r.fail = fail; r.vc = vc;
        return r;
    endfunction

    function automatic logic [13:0] obs();
        return {open_gate, close_gate, alarm_wrong_pin, alarm_blocked, fail_count, vehicle_count};
    endfunction

    // Drive one cycle of inputs, queue the expected registered response, advance past the edge.
    task automatic apply(input row_t r);
        {rst, sensor_vehicule, sensor_moved_vehicule, password_valid} = r.ctl;
        password_input   = r.pin;
        correct_password = r.cp;
        sb.push_back({r.flags[2], ~r.flags[2], r.flags[1], r.flags[0], r.fail, r.vc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(NONE, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(PV, PIN, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL reset[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_open_pass();
        row_t rows[$];
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, 16'h1234, OPN, 2'd0, 8'd0));
        rows.push_back(mk(NONE, 16'h0, OPN, 2'd0, 8'd0));
        rows.push_back(mk(SMV, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(NONE, 16'h0, CLS, 2'd0, 8'd1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL open_pass[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_fail_recover();
        row_t rows[$];
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, 16'h1235, CLS, 2'd1, 8'd0));
        rows.push_back(mk(SV | PV, 16'h1234, CLS, 2'd2, 8'd0));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        rows.push_back(mk(SMV, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(SV | PV, 16'h1111, CLS, 2'd1, 8'd1));
        rows.push_back(mk(NONE, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(PV, 16'h1111, CLS, 2'd1, 8'd1));
        rows.push_back(mk(NONE, 16'h0, CLS, 2'd0, 8'd1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL fail_recover[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_wrong_pin();
        row_t rows[$];
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, 16'h1235, CLS, 2'd1, 8'd0));
        rows.push_back(mk(SV | PV, 16'h1234, CLS, 2'd2, 8'd0));
        rows.push_back(mk(SV | PV, 16'h1368, AW, 2'd3, 8'd0));
        rows.push_back(mk(NONE, 16'h0, AW, 2'd3, 8'd0));
        rows.push_back(mk(PV, 16'h1111, AW, 2'd3, 8'd0));
        rows.push_back(mk(SV, 16'h0, AW, 2'd3, 8'd0));
        rows.push_back(mk(PV, PIN, OPN, 2'd0, 8'd0));
        rows.push_back(mk(SMV, 16'h0, CLS, 2'd0, 8'd1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL wrong_pin[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_blocked();
        row_t rows[$];
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        rows.push_back(mk(SV | SMV, 16'h0, AB, 2'd0, 8'd0));
        rows.push_back(mk(SV | SMV | PV, PIN, AB, 2'd0, 8'd0));
        rows.push_back(mk(PV, 16'h1234, AB, 2'd0, 8'd0));
        rows.push_back(mk(SMV | PV, PIN, AB, 2'd0, 8'd0));
        rows.push_back(mk(PV, PIN, CLS, 2'd0, 8'd0));
        rows.push_back(mk(NONE, 16'h0, CLS, 2'd0, 8'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL blocked[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_nonbcd_rst();
        row_t rows[$];
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, 16'h37A1, CLS, 2'd1, 8'd0));
        rows.push_back(mk(SV | PV, 16'h37A1, CLS, 2'd2, 8'd0));
        rows[3].cp = 16'h37A1;
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        rows.push_back(mk(SMV, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd1));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd1));
        rows.push_back(mk(RST | SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL nonbcd_rst[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_count_wrap();
        row_t rows[$];
        logic [7:0] vc = 8'd0;
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        for (int n = 0; n < 256; n++) begin
            rows.push_back(mk(SV, 16'h0, CLS, 2'd0, vc));
            rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, vc));
            vc = vc + 8'd1;
            rows.push_back(mk(SMV, 16'h0, CLS, 2'd0, vc));
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL count_wrap[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        logic [2:0] f;
        rows.push_back(mk(RST, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV, 16'h0, CLS, 2'd0, 8'd0));
        rows.push_back(mk(SV | PV, PIN, OPN, 2'd0, 8'd0));
        for (int j = 1; j <= 50; j++) begin
`ifdef GATE_TIMEOUT_EN
            f = (j < 10) ? OPN : CLS;
`else
            f = OPN;
`endif
            rows.push_back(mk(NONE, 16'h0, f, 2'd0, 8'd0));
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            got = obs(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++; $display("FAIL timeout[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_open_pass();
        test_fail_recover();
        test_wrong_pin();
        test_blocked();
        test_nonbcd_rst();
        test_count_wrap();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
